// File: rtl/kamus_pkg.sv
// kamus_pkg: shared types for the kamus memory arbiter
package kamus_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;
  typedef enum logic {SRC_INSTR, SRC_DATA} arb_src_e;
endpackage

// File: rtl/kamus_mem_arbiter.sv
// kamus_mem_arbiter: round-robin share of one memory port between fetch and data.
// Define KAMUS_ARB_TIMEOUT_EN to abort accesses that see no mem_ack_i within TIMEOUT_CYCLES.
module kamus_mem_arbiter
  import kamus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,
  output logic                instr_err_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);
  arb_state_e state_q, state_d;
  arb_src_e src_q, src_d, last_q, last_d;
  logic we_q, we_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic timeout, err_q;
  // on a tie the port that did not win last time goes first
  assign instr_gnt_o = state_q == IDLE && instr_req_i && (!data_req_i || last_q == SRC_DATA);
  assign data_gnt_o = state_q == IDLE && data_req_i && !instr_gnt_o;
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    last_d = last_q;
    we_d = we_q;
    be_d = be_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (instr_gnt_o || data_gnt_o) begin
      src_d = data_gnt_o ? SRC_DATA : SRC_INSTR;
      last_d = src_d;
      we_d = data_gnt_o && data_we_i;
      be_d = data_gnt_o ? data_be_i : '1;
      addr_d = data_gnt_o ? data_addr_i : instr_addr_i;
      wdata_d = data_gnt_o ? data_wdata_i : '0;
      state_d = BUSY;
    end
    if (state_q == BUSY && (mem_ack_i || timeout)) begin
      rdata_d = (mem_ack_i && !we_q) ? mem_rdata_i : '0;
      state_d = RESP;
    end
    if (state_q == RESP) state_d = IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      src_q <= SRC_INSTR;
      last_q <= SRC_INSTR;
      we_q <= 1'b0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      last_q <= last_d;
      we_q <= we_d;
      be_q <= be_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
`ifdef KAMUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_d;
  // an ack in the expiring cycle wins over the timeout
  always_comb begin
    cnt_d = state_q == BUSY ? cnt_q + 1'b1 : '0;
    timeout = state_q == BUSY && !mem_ack_i && cnt_d == CW'(TIMEOUT_CYCLES);
    err_d = state_q == BUSY ? timeout : err_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
`else
  assign timeout = 1'b0;
  assign err_q = 1'b0;
`endif
  assign mem_req_o = state_q == BUSY;
  assign mem_we_o = we_q;
  assign mem_be_o = be_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign instr_rvalid_o = state_q == RESP && src_q == SRC_INSTR;
  assign data_rvalid_o = state_q == RESP && src_q == SRC_DATA;
  assign instr_rdata_o = instr_rvalid_o ? rdata_q : '0;
  assign data_rdata_o = data_rvalid_o ? rdata_q : '0;
  assign instr_err_o = instr_rvalid_o && err_q;
  assign data_err_o = data_rvalid_o && err_q;
endmodule

// File: tb/tb_kamus_mem_arbiter.sv
// tb_kamus_mem_arbiter: scoreboard bench for the fetch/data memory arbiter
module tb_kamus_mem_arbiter;
  localparam int TO = 4;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic instr_req_i = 0, data_req_i = 0, data_we_i = 0, mem_ack_i = 0;
  logic [31:0] instr_addr_i = 0, data_addr_i = 0, data_wdata_i = 0, mem_rdata_i = 0;
  logic [3:0] data_be_i = 0;
  logic instr_gnt_o, instr_rvalid_o, instr_err_o, data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
  logic mem_req_o, mem_we_o;
  logic [3:0] mem_be_o;
  typedef struct packed {logic is_data; logic [31:0] rdata; logic err;} rsp_t;
  rsp_t sb[$];
  int total = 0, bad = 0, ack_delay = 0, busy_cnt = 0;
  bit no_ack = 0;
  kamus_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a == 32'h100 ? 32'hDEAD_BEEF : a * 3 + 32'h11;
  endfunction
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  // memory model: acks after ack_delay idle request cycles unless no_ack
  initial forever begin
    tick;
    if (mem_req_o && !rst_i) begin
      mem_ack_i = !no_ack && busy_cnt == ack_delay;
      mem_rdata_i = mem_ack_i ? rd_of(mem_addr_o) : 32'h0;
      busy_cnt++;
    end else begin
      mem_ack_i = 0;
      busy_cnt = 0;
    end
  end
  initial forever begin
    rsp_t e;
    tick;
    if (!rst_i && (instr_rvalid_o || data_rvalid_o)) begin
      check("rv_one_hot", instr_rvalid_o && data_rvalid_o, 0);
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rv_port", data_rvalid_o, e.is_data);
        check("rv_rdata", data_rvalid_o ? data_rdata_o : instr_rdata_o, e.rdata);
        check("rv_err", data_rvalid_o ? data_err_o : instr_err_o, e.err);
      end
    end
  end
  task automatic start(input bit is_data, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit err);
    if (is_data) begin
      data_req_i = 1; data_we_i = we; data_be_i = be; data_addr_i = addr; data_wdata_i = wdata;
    end else begin
      instr_req_i = 1; instr_addr_i = addr;
    end
    sb.push_back('{is_data, (err || (is_data && we)) ? 32'h0 : rd_of(addr), err});
    #1;
    check("gnt_port", {data_gnt_o, instr_gnt_o}, is_data ? 2'b10 : 2'b01);
    tick;
    data_req_i = 0;
    instr_req_i = 0;
    check("mem_req", mem_req_o, 1);
    check("mem_addr", mem_addr_o, addr);
    check("mem_we", mem_we_o, is_data && we);
    check("mem_be", mem_be_o, is_data ? be : 4'hF);
    if (is_data) check("mem_wdata", mem_wdata_o, wdata);
  endtask
  task automatic wait_rv(input int lat);
    int n = 1;
    while (!(instr_rvalid_o || data_rvalid_o) && n < 60) begin
      tick;
      n++;
    end
    check("rv_latency", n, lat);
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int g, last_c;
    bit exp_d;
    tick;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_attr", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 0);
    check("rst_rv", {instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}, 0);
    check("rst_rdata", {instr_rdata_o, data_rdata_o}, 0);
    rst_i = 0;
    tick;
    start(0, 0, 4'hF, 32'h100, 0, 0);
    wait_rv(2);
    data_addr_i = 32'h400; data_we_i = 0; data_be_i = 4'hF; instr_addr_i = 32'h300;
    data_req_i = 1; instr_req_i = 1;
    exp_d = 1; g = 0; last_c = 0;
    for (int c = 0; c < 40 && g < 4; c++) begin
      #1;
      if (instr_gnt_o || data_gnt_o) begin
        check("tie_gnt", {data_gnt_o, instr_gnt_o}, exp_d ? 2'b10 : 2'b01);
        if (g > 0) check("tie_spacing", c - last_c, 3);
        sb.push_back('{exp_d, rd_of(exp_d ? 32'h400 : 32'h300), 1'b0});
        exp_d = !exp_d; g++; last_c = c;
      end
      tick;
    end
    check("tie_count", g, 4);
    data_req_i = 0; instr_req_i = 0;
    repeat (3) tick;
    check("tie_drained", sb.size(), 0);
    start(1, 1, 4'b0011, 32'h2000, 32'h1234, 0);
    wait_rv(2);
    ack_delay = 5;
    start(1, 0, 4'hF, 32'h500, 0, 0);
    for (int i = 0; i < 5; i++) begin
      instr_req_i = 1; instr_addr_i = 32'h600;
      #1;
      check("ws_no_gnt", instr_gnt_o, 0);
      check("ws_mem_req", mem_req_o, 1);
      check("ws_addr", mem_addr_o, 32'h500);
      tick;
    end
    check("ws_no_rv_at_ack", data_rvalid_o, 0);
    tick;
    check("ws_rv", data_rvalid_o, 1);
    check("ws_no_gnt_resp", instr_gnt_o, 0);
    tick;
    ack_delay = 0;
    start(0, 0, 4'hF, 32'h600, 0, 0);
    wait_rv(2);
`ifdef KAMUS_ARB_TIMEOUT_EN
    no_ack = 1;
    start(0, 0, 4'hF, 32'h700, 0, 1);
    for (int i = 0; i < TO; i++) begin
      check("to_mem_req", mem_req_o, 1);
      tick;
    end
    check("to_req_drop", mem_req_o, 0);
    check("to_err", instr_err_o, 1);
    tick;
    no_ack = 0; ack_delay = TO - 1;
    start(1, 0, 4'hF, 32'h704, 0, 0);
    wait_rv(TO + 1);
    ack_delay = 0;
`endif
    no_ack = 1;
    start(0, 0, 4'hF, 32'h800, 0, 0);
    tick;
    rst_i = 1;
    #1;
    check("rb_mem_req", mem_req_o, 0);
    check("rb_mem_addr", mem_addr_o, 0);
    check("rb_rv", {instr_rvalid_o, data_rvalid_o}, 0);
    sb.delete();
    tick;
    tick;
    rst_i = 0; no_ack = 0;
    tick;
    check("rb_no_rv", {instr_rvalid_o, data_rvalid_o}, 0);
    instr_req_i = 1; instr_addr_i = 32'h900;
    start(1, 0, 4'hF, 32'hA00, 0, 0);
    wait_rv(2);
    start(0, 0, 4'hF, 32'h900, 0, 0);
    wait_rv(2);
    repeat (2) tick;
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
